// File: rtl/alu_pkg.sv
// Shared opcode encoding, flag bit positions and opcode classification for the ARM ALU.
// Latency: none (declarations only).
// Backpressure: none (declarations only).
//
// Contents:
//   alu_op_e    - 4-bit data-processing opcode, numbered as in the ARM instruction encoding
//   FLAG_*      - bit positions of N/Z/C/V inside the 4-bit flag vector
//   is_logical  - true for opcodes whose C comes from the shifter and whose V is passed through
package alu_pkg;

    typedef enum logic [3:0] {
        OP_AND = 4'h0,
        OP_EOR = 4'h1,
        OP_SUB = 4'h2,
        OP_RSB = 4'h3,
        OP_ADD = 4'h4,
        OP_ADC = 4'h5,
        OP_SBC = 4'h6,
        OP_RSC = 4'h7,
        OP_TST = 4'h8,
        OP_TEQ = 4'h9,
        OP_CMP = 4'hA,
        OP_CMN = 4'hB,
        OP_ORR = 4'hC,
        OP_MOV = 4'hD,
        OP_BIC = 4'hE,
        OP_MVN = 4'hF
    } alu_op_e;

    // Flag vector layout: {N, Z, C, V}
    localparam int FLAG_N = 3;
    localparam int FLAG_Z = 2;
    localparam int FLAG_C = 1;
    localparam int FLAG_V = 0;

    // Logical ops never use the adder result.
    // Their carry is the shifter carry-out, and their overflow is left untouched.
    function automatic logic is_logical(input alu_op_e op);
        case (op)
            OP_AND, OP_EOR, OP_TST, OP_TEQ,
            OP_ORR, OP_MOV, OP_BIC, OP_MVN: return 1'b1;
            default:                        return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/arm_alu_if.sv
// Operand/result bundle between the execute-stage controller and the ALU.
// Latency: none (wires only).
// Backpressure: none; the bundle has no handshake, and the ALU accepts new operands every cycle.
//
// Signals:
//   A, B       - operands (Rn, shifted operand 2)
//   C, V       - current carry / overflow flags fed back by the outer datapath
//   S          - set-flags enable
//   ALU_OP     - opcode (alu_pkg::alu_op_e encoding)
//   shiftCout  - barrel-shifter carry-out
//   F, NZCV    - result and registered flags
// Modports: master drives operands and control; slave is the ALU.
interface arm_alu_if #(
    parameter int WIDTH = 32
);
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic             C;
    logic             V;
    logic             S;
    logic [3:0]       ALU_OP;
    logic             shiftCout;
    logic [WIDTH-1:0] F;
    logic [3:0]       NZCV;

    modport master (
        output A, B, C, V, S, ALU_OP, shiftCout,
        input  F, NZCV
    );

    modport slave (
        input  A, B, C, V, S, ALU_OP, shiftCout,
        output F, NZCV
    );

endinterface

// File: rtl/alu_addsub.sv
// Single shared (WIDTH+1)-bit adder for every arithmetic opcode.
// Latency: combinational, 0 cycles.
// Backpressure: none.
//
// Ports:
//   x, y  - adder operands, already inverted by the caller for subtracts
//   cin   - carry-in
//   sum   - low WIDTH bits of x + y + cin
//   cout  - bit WIDTH of the sum (NOT-borrow for subtracts)
//   ovf   - signed overflow of x + y + cin
module alu_addsub #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] x,
    input  logic [WIDTH-1:0] y,
    input  logic             cin,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);

    logic [WIDTH:0] wide;

    assign wide = {1'b0, x} + {1'b0, y} + {{WIDTH{1'b0}}, cin};
    assign sum  = wide[WIDTH-1:0];
    assign cout = wide[WIDTH];

    // Overflow occurs only when both operands have the same sign and the result sign differs.
    // Both operands here are the values that were actually fed to the adder.
    assign ovf = (x[WIDTH-1] == y[WIDTH-1]) && (sum[WIDTH-1] != x[WIDTH-1]);

endmodule

// File: rtl/arm_alu.sv
// ARM-style data-processing ALU with a registered NZCV flag set.
// Latency: F 0 cycles (1 cycle with ALU_OUT_REG_EN); NZCV 1 cycle after an edge where S=1.
// Backpressure: none; a new operation is accepted every cycle.
//
// Ports:
//   clk  - clock; the flag register (and F, when registered) update on the rising edge
//   rst  - synchronous active-high reset; clears NZCV (and F when registered)
//   bus  - arm_alu_if.slave: inputs A, B, C, V, S, ALU_OP, shiftCout; outputs F, NZCV
// Build option: define ALU_OUT_REG_EN to register F alongside NZCV.
module arm_alu
    import alu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic     clk,
    input  logic     rst,
    arm_alu_if.slave bus
);

    alu_op_e          op;
    logic [WIDTH-1:0] add_x;
    logic [WIDTH-1:0] add_y;
    logic             add_cin;
    logic [WIDTH-1:0] add_sum;
    logic             add_cout;
    logic             add_ovf;
    logic [WIDTH-1:0] f_comb;
    logic [3:0]       flags_next;
    logic [3:0]       nzcv_q;

    assign op = alu_op_e'(bus.ALU_OP);

    // Adder operand steering.
    // Subtracts invert the subtrahend, and the carry-in supplies either the +1 or the incoming C flag.
    // Logical ops leave the adder on A+B; its result is ignored for them.
    always_comb begin
        add_x   = bus.A;
        add_y   = bus.B;
        add_cin = 1'b0;
        case (op)
            OP_SUB, OP_CMP: begin
                add_x   = bus.A;
                add_y   = ~bus.B;
                add_cin = 1'b1;
            end
            OP_RSB: begin
                add_x   = bus.B;
                add_y   = ~bus.A;
                add_cin = 1'b1;
            end
            OP_ADD, OP_CMN: begin
                add_x   = bus.A;
                add_y   = bus.B;
                add_cin = 1'b0;
            end
            OP_ADC: begin
                add_x   = bus.A;
                add_y   = bus.B;
                add_cin = bus.C;
            end
            OP_SBC: begin
                add_x   = bus.A;
                add_y   = ~bus.B;
                add_cin = bus.C;
            end
            OP_RSC: begin
                add_x   = bus.B;
                add_y   = ~bus.A;
                add_cin = bus.C;
            end
            default: begin
                add_x   = bus.A;
                add_y   = bus.B;
                add_cin = 1'b0;
            end
        endcase
    end

    alu_addsub #(
        .WIDTH (WIDTH)
    ) u_addsub (
        .x    (add_x),
        .y    (add_y),
        .cin  (add_cin),
        .sum  (add_sum),
        .cout (add_cout),
        .ovf  (add_ovf)
    );

    // Result select.
    // Test/compare opcodes still drive F; whether F gets written back is the caller's decision.
    always_comb begin
        f_comb = add_sum;
        case (op)
            OP_AND, OP_TST: f_comb = bus.A & bus.B;
            OP_EOR, OP_TEQ: f_comb = bus.A ^ bus.B;
            OP_ORR:         f_comb = bus.A | bus.B;
            OP_MOV:         f_comb = bus.B;
            OP_BIC:         f_comb = bus.A & ~bus.B;
            OP_MVN:         f_comb = ~bus.B;
            default:        f_comb = add_sum;
        endcase
    end

    // Next flag values.
    // The C/V inputs are the caller's view of the current flags.
    // This block never feeds nzcv_q back into itself.
    always_comb begin
        flags_next         = 4'b0000;
        flags_next[FLAG_N] = f_comb[WIDTH-1];
        flags_next[FLAG_Z] = (f_comb == '0);
        if (is_logical(op)) begin
            flags_next[FLAG_C] = bus.shiftCout;
            flags_next[FLAG_V] = bus.V;
        end else begin
            flags_next[FLAG_C] = add_cout;
            flags_next[FLAG_V] = add_ovf;
        end
    end

    // Reset wins over S, so an update requested in the same cycle as reset is discarded.
    always_ff @(posedge clk) begin
        if (rst) begin
            nzcv_q <= 4'b0000;
        end else if (bus.S) begin
            nzcv_q <= flags_next;
        end
    end

    assign bus.NZCV = nzcv_q;

`ifdef ALU_OUT_REG_EN
    // Registered result, aligned with the flag register.
    // F updates every cycle, regardless of S.
    logic [WIDTH-1:0] f_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            f_q <= '0;
        end else begin
            f_q <= f_comb;
        end
    end

    assign bus.F = f_q;
`else
    assign bus.F = f_comb;
`endif

endmodule

// File: tb/tb_arm_alu.sv
// Directed and random checks of arm_alu.
// A scoreboard queue holds the expected F/NZCV from a reference model.
// Latency: F is checked before the edge (after it when registered); NZCV is checked 1 cycle after.
// Backpressure: none.
module tb_arm_alu;
    import alu_pkg::*;

    logic clk;
    logic rst;
    int   checks;
    int   failures;

    logic [31:0] exp_f_q[$];
    logic [3:0]  exp_nzcv_q[$];
    logic [3:0]  model_nzcv;

    arm_alu_if #(.WIDTH(32)) bus ();

    arm_alu #(.WIDTH(32)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model.
    // C and V are computed from unsigned/signed 64-bit arithmetic, not from an adder.
    function automatic void model(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                                  input logic c, input logic vin, input logic sc,
                                  output logic [31:0] f, output logic [3:0] fl);
        longint      sa;
        longint      sb;
        longint      sr;
        logic [63:0] ua;
        logic [63:0] ub;
        logic        cy;
        logic        ov;
        logic        arith;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = {32'b0, a};
        ub = {32'b0, b};
        sr = 0;
        cy = sc;
        ov = vin;
        arith = 1'b1;
        f = 32'h0;
        case (op)
            4'h0, 4'h8: begin f = a & b; arith = 1'b0; end
            4'h1, 4'h9: begin f = a ^ b; arith = 1'b0; end
            4'hC: begin f = a | b;  arith = 1'b0; end
            4'hD: begin f = b;      arith = 1'b0; end
            4'hE: begin f = a & ~b; arith = 1'b0; end
            4'hF: begin f = ~b;     arith = 1'b0; end
            4'h2, 4'hA: begin f = a - b; sr = sa - sb; cy = (a >= b); end
            4'h3: begin f = b - a; sr = sb - sa; cy = (b >= a); end
            4'h4, 4'hB: begin f = a + b; sr = sa + sb; cy = (ua + ub) > 64'hFFFF_FFFF; end
            4'h5: begin
                f  = a + b + 32'(c);
                sr = sa + sb + longint'(c);
                cy = (ua + ub + 64'(c)) > 64'hFFFF_FFFF;
            end
            4'h6: begin
                f  = a - b - 32'(!c);
                sr = sa - sb - longint'(!c);
                cy = ua >= (ub + 64'(!c));
            end
            default: begin
                f  = b - a - 32'(!c);
                sr = sb - sa - longint'(!c);
                cy = ub >= (ua + 64'(!c));
            end
        endcase
        if (arith) ov = (sr > 64'sd2147483647) || (sr < -64'sd2147483648);
        fl = {f[31], (f == 32'h0), cy, ov};
    endfunction

    task automatic check_f(input string tag);
        logic [31:0] e;
        checks++;
        if (exp_f_q.size() == 0) begin
            failures++;
            $error("FAIL %s F: got=%h but scoreboard empty", tag, bus.F);
        end else begin
            e = exp_f_q.pop_front();
            assert (bus.F === e) else begin
                failures++;
                $error("FAIL %s F: got=%h exp=%h", tag, bus.F, e);
            end
        end
    endtask

    task automatic check_nzcv(input string tag);
        logic [3:0] e;
        checks++;
        if (exp_nzcv_q.size() == 0) begin
            failures++;
            $error("FAIL %s NZCV: got=%b but scoreboard empty", tag, bus.NZCV);
        end else begin
            e = exp_nzcv_q.pop_front();
            assert (bus.NZCV === e) else begin
                failures++;
                $error("FAIL %s NZCV: got=%b exp=%b", tag, bus.NZCV, e);
            end
        end
    endtask

    task automatic step(input string tag, input logic r, input logic [3:0] op,
                        input logic [31:0] a, input logic [31:0] b,
                        input logic c, input logic v, input logic s, input logic sc);
        logic [31:0] ef;
        logic [3:0]  efl;
        @(negedge clk);
        rst           = r;
        bus.ALU_OP    = op;
        bus.A         = a;
        bus.B         = b;
        bus.C         = c;
        bus.V         = v;
        bus.S         = s;
        bus.shiftCout = sc;
        model(op, a, b, c, v, sc, ef, efl);
        if (r) model_nzcv = 4'b0000;
        else if (s) model_nzcv = efl;
        exp_nzcv_q.push_back(model_nzcv);
`ifdef ALU_OUT_REG_EN
        exp_f_q.push_back(r ? 32'h0 : ef);
`else
        exp_f_q.push_back(ef);
        #1;
        check_f(tag);
`endif
        @(posedge clk);
        #1;
`ifdef ALU_OUT_REG_EN
        check_f(tag);
`endif
        check_nzcv(tag);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [3:0] rop;
        checks        = 0;
        failures      = 0;
        model_nzcv    = 4'b0000;
        rst           = 1'b1;
        bus.A         = 32'h0;
        bus.B         = 32'h0;
        bus.C         = 1'b0;
        bus.V         = 1'b0;
        bus.S         = 1'b0;
        bus.ALU_OP    = 4'h0;
        bus.shiftCout = 1'b0;

        //           tag         rst  op      A             B             C     V     S     sc
        step("reset",     1'b1, OP_ADD, 32'h7FFFFFFF, 32'h1,        1'b0, 1'b0, 1'b1, 1'b0);
        step("add_ovf",   1'b0, OP_ADD, 32'h7FFFFFFF, 32'h1,        1'b0, 1'b0, 1'b1, 1'b0);
        step("cmp_eq",    1'b0, OP_CMP, 32'd5,        32'd5,        1'b0, 1'b0, 1'b1, 1'b0);
        step("sub_neg",   1'b0, OP_SUB, 32'd3,        32'd5,        1'b0, 1'b0, 1'b1, 1'b0);
        step("adc_wrap",  1'b0, OP_ADC, 32'hFFFFFFFF, 32'h0,        1'b1, 1'b0, 1'b1, 1'b0);
        step("sbc_c0",    1'b0, OP_SBC, 32'd5,        32'd2,        1'b0, 1'b0, 1'b1, 1'b0);
        step("mov_zero",  1'b0, OP_MOV, 32'h12345678, 32'h0,        1'b0, 1'b1, 1'b1, 1'b1);
        step("mvn_zero",  1'b0, OP_MVN, 32'h0,        32'h0,        1'b0, 1'b0, 1'b1, 1'b0);
        step("sub_eq",    1'b0, OP_SUB, 32'd5,        32'd5,        1'b0, 1'b0, 1'b1, 1'b0);
        step("hold_s0",   1'b0, OP_ADD, 32'h7FFFFFFF, 32'h1,        1'b0, 1'b0, 1'b0, 1'b0);
        step("rsb_ovf",   1'b0, OP_RSB, 32'h1,        32'h80000000, 1'b0, 1'b0, 1'b1, 1'b0);
        step("rsc_c1",    1'b0, OP_RSC, 32'd2,        32'd7,        1'b1, 1'b0, 1'b1, 1'b1);
        step("rst_vs_s",  1'b1, OP_SUB, 32'd3,        32'd5,        1'b0, 1'b0, 1'b1, 1'b1);

        for (int i = 0; i < 16; i++) begin
            step($sformatf("sweep_op%0h", i), 1'b0, 4'(i), 32'hF0F0F0F0, 32'h0FF00FF0,
                 1'b1, 1'(i >> 1), 1'b1, 1'(i));
        end

        for (int i = 0; i < 12; i++) begin
            rop = 4'($urandom_range(15, 0));
            step($sformatf("rand%0d_op%0h", i, rop), 1'b0, rop, $urandom, $urandom,
                 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/arm_alu.md
Name: arm_alu

Overview:
- 32-bit ARM-style data-processing ALU. Executes the 16 ARM data-processing opcodes on operands A (Rn) and B (shifted operand 2).
- Produces result F combinationally.
- Maintains a registered NZCV condition-flag set, updated on a clock edge when S=1.
- Sits after the barrel shifter in the execute stage; shiftCout comes from that shifter.

Parameters:
- WIDTH, 32, datapath width; flags are always 4 bits. Only 32 is required to be verified.

Ports:
- clk  input  1  clock; flag register updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- A  input  32  first operand (Rn).
- B  input  32  second operand (shifter output).
- C  input  1  current carry flag; carry-in for ADC/SBC/RSC.
- V  input  1  current overflow flag; passed through on logical ops.
- S  input  1  set-flags enable.
- ALU_OP  input  4  opcode.
- shiftCout  input  1  shifter carry-out; becomes C on logical ops.
- F  output  32  result.
- NZCV  output  4  flag register, bit3=N, bit2=Z, bit1=C, bit0=V.

Behaviour:
- Opcode map (F):
  - 0 AND: A&B
  - 1 EOR: A^B
  - 2 SUB: A+~B+1
  - 3 RSB: B+~A+1
  - 4 ADD: A+B
  - 5 ADC: A+B+C
  - 6 SBC: A+~B+C
  - 7 RSC: B+~A+C
  - 8 TST: A&B
  - 9 TEQ: A^B
  - A CMP: A+~B+1
  - B CMN: A+B
  - C ORR: A|B
  - D MOV: B
  - E BIC: A&~B
  - F MVN: ~B
- F is combinational from the current inputs for every opcode, including TST/TEQ/CMP/CMN. Register writeback is the caller's decision.
- Arithmetic uses a single 33-bit add of (x, y, cin). The x/y/cin operands are exactly as listed in the opcode map.
- Arithmetic flags:
  - C = bit 32 of the sum. For subtracts this is NOT-borrow.
  - V = (x[31]==y[31]) && (F[31]!=x[31]), where x/y are the operands actually fed to the adder after inversion.
- Logical ops (0,1,8,9,C,D,E,F): next C = shiftCout, next V = V input.
- All ops: N = F[31]; Z = (F==0).
- Flag register:
  - On rising clk, if rst=1: NZCV <= 0.
  - Else if S=1: NZCV <= computed flags.
  - Else: hold.
- Reset value: NZCV=4'b0000. F has no reset (combinational).
- Latency: F is 0 cycles; NZCV is visible 1 cycle after the edge on which S=1 was sampled.
- Reset has priority over S when both are high. Reset mid-sequence discards any pending update.
- The C/V inputs are used as given. The block does not feed back its own NZCV internally; the outer datapath wires NZCV back to C/V.

Optional Feature:
- Macro ALU_OUT_REG_EN.
- When defined: F is also registered. It updates every rising edge from the combinational result, resets to 0 on rst, and has 1-cycle latency aligned with NZCV.
- When undefined: F is purely combinational as above.

Decomposition:
- Package alu_pkg:
  - 4-bit opcode enum (OP_AND … OP_MVN).
  - Flag bit index constants (FLAG_N=3, FLAG_Z=2, FLAG_C=1, FLAG_V=0).
  - Helper function is_logical(op).
- Sub-module alu_addsub: 33-bit adder taking x, y, cin; returns sum[31:0], cout and ovf. Instantiated once, with operand/cin selection muxed by opcode in arm_alu.

Test Plan:
- Reset: rst=1 for one edge with S=1 and ADD operands present -> NZCV=0000 after the edge.
- Overflow: ADD A=0x7FFFFFFF, B=1, S=1 -> F=0x80000000; NZCV=1001 after the edge.
- Compare equal: SUB/CMP A=5, B=5, S=1 -> F=0; NZCV=0110. Follow with SUB A=3, B=5 -> F=0xFFFFFFFE; NZCV=1000.
- Carry-in: ADC A=0xFFFFFFFF, B=0, C=1 -> F=0, NZCV=0110. SBC A=5, B=2, C=0 -> F=2; NZCV C=1.
- Logical flags: MOV B=0, shiftCout=1, V=1, S=1 -> F=0; NZCV=0111. MVN B=0 -> F=0xFFFFFFFF; N=1.
- Flag hold: S=0 with ADD 0x7FFFFFFF+1 after a prior NZCV=0110 -> F=0x80000000, NZCV stays 0110. Sweep all 16 opcodes on A=0xF0F0F0F0, B=0x0FF00FF0, checking F against the opcode map.
